// File: rtl/frame_loader.sv
// Byte-serial frame loader: header + payload assembled into a 784-bit image or a layer command strobe.
// Optional trailer checksum when FRAME_LOADER_CHECKSUM_EN is defined.
module frame_loader #(
  parameter int unsigned PAYLOAD_IMG = 98,
  parameter int unsigned PAYLOAD_CMD = 30
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [783:0] image,
  output logic         image_out_valid,
  input  logic         image_out_ready,
  output logic [1:0]   kernel_layer,
  output logic [1:0]   offset_layer,
  output logic [7:0]   err_count
);

  localparam int unsigned IMG_W = 784;
  localparam int unsigned MAX_P = (PAYLOAD_IMG > PAYLOAD_CMD) ? PAYLOAD_IMG : PAYLOAD_CMD;
  localparam int unsigned CNT_W = $clog2(MAX_P);

  localparam logic [1:0] KIND_IMG = 2'd0;
  localparam logic [1:0] KIND_KER = 2'd1;
  localparam logic [1:0] KIND_OFF = 2'd2;
  localparam logic [1:0] KIND_BAD = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE_IMG,
    ISSUE_CMD,
    DROP
`ifdef FRAME_LOADER_CHECKSUM_EN
    , CHECK
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         kind_q, kind_d;
  logic [1:0]         layer_q, layer_d;
  logic [IMG_W-1:0]   image_q, image_d;
  logic               in_ready_q, in_ready_d;
  logic               valid_q, valid_d;
  logic [1:0]         kl_q, kl_d;
  logic [1:0]         ol_q, ol_d;
  logic [7:0]         err_q, err_d;
`ifdef FRAME_LOADER_CHECKSUM_EN
  logic [7:0]         xor_q, xor_d;
`endif

  logic               accept;
  logic               err_inc;
  logic [CNT_W-1:0]   last_idx;
  state_t             issue_state;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    kind_d     = kind_q;
    layer_d    = layer_q;
    image_d    = image_q;
    err_inc    = 1'b0;
`ifdef FRAME_LOADER_CHECKSUM_EN
    xor_d      = xor_q;
`endif
    accept      = in_valid && in_ready_q;
    last_idx    = (kind_q == KIND_IMG) ? CNT_W'(PAYLOAD_IMG - 1) : CNT_W'(PAYLOAD_CMD - 1);
    issue_state = (kind_q == KIND_IMG) ? ISSUE_IMG : ISSUE_CMD;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if ((in_data[1:0] == KIND_BAD) ||
              ((in_data[1:0] != KIND_IMG) && (in_data[3:2] == 2'd0))) begin
            err_inc = 1'b1;
          end else begin
            state_d = LOAD;
            cnt_d   = '0;
            kind_d  = in_data[1:0];
            layer_d = in_data[3:2];
            image_d = '0;
`ifdef FRAME_LOADER_CHECKSUM_EN
            xor_d   = '0;
`endif
          end
        end
      end
      LOAD: begin
        if (accept) begin
          image_d[{cnt_q, 3'b000} +: 8] = in_data;
`ifdef FRAME_LOADER_CHECKSUM_EN
          xor_d = xor_q ^ in_data;
`endif
          if (cnt_q == last_idx) begin
            cnt_d = '0;
`ifdef FRAME_LOADER_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = issue_state;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`ifdef FRAME_LOADER_CHECKSUM_EN
      CHECK: begin
        if (accept) begin
          if (in_data == xor_q) begin
            state_d = issue_state;
          end else begin
            err_inc = 1'b1;
            state_d = IDLE;
          end
        end
      end
`endif
      ISSUE_IMG: if (image_out_ready) state_d = IDLE;
      ISSUE_CMD: state_d = IDLE;
      DROP:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    err_d = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;

    // Outputs registered from the next state so strobes appear the cycle after the last byte
    in_ready_d = (state_d == IDLE) || (state_d == LOAD);
`ifdef FRAME_LOADER_CHECKSUM_EN
    if (state_d == CHECK) in_ready_d = 1'b1;
`endif
    valid_d = (state_d == ISSUE_IMG);
    kl_d    = ((state_d == ISSUE_CMD) && (kind_d == KIND_KER)) ? layer_d : 2'd0;
    ol_d    = ((state_d == ISSUE_CMD) && (kind_d == KIND_OFF)) ? layer_d : 2'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      kind_q     <= KIND_IMG;
      layer_q    <= 2'd0;
      image_q    <= '0;
      in_ready_q <= 1'b0;
      valid_q    <= 1'b0;
      kl_q       <= 2'd0;
      ol_q       <= 2'd0;
      err_q      <= 8'd0;
`ifdef FRAME_LOADER_CHECKSUM_EN
      xor_q      <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      kind_q     <= kind_d;
      layer_q    <= layer_d;
      image_q    <= image_d;
      in_ready_q <= in_ready_d;
      valid_q    <= valid_d;
      kl_q       <= kl_d;
      ol_q       <= ol_d;
      err_q      <= err_d;
`ifdef FRAME_LOADER_CHECKSUM_EN
      xor_q      <= xor_d;
`endif
    end
  end

  assign in_ready        = in_ready_q;
  assign image           = image_q;
  assign image_out_valid = valid_q;
  assign kernel_layer    = kl_q;
  assign offset_layer    = ol_q;
  assign err_count       = err_q;

endmodule

// File: tb/tb_frame_loader.sv
// Randomized bench for frame_loader: frame-level reference model compared every cycle plus literal pins.
module tb_frame_loader;

  localparam int unsigned P_IMG = 98;
  localparam int unsigned P_CMD = 30;

  logic         clk;
  logic         rst;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic [783:0] image;
  logic         image_out_valid;
  logic         image_out_ready;
  logic [1:0]   kernel_layer;
  logic [1:0]   offset_layer;
  logic [7:0]   err_count;

  frame_loader #(.PAYLOAD_IMG(P_IMG), .PAYLOAD_CMD(P_CMD)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .image(image), .image_out_valid(image_out_valid), .image_out_ready(image_out_ready),
    .kernel_layer(kernel_layer), .offset_layer(offset_layer), .err_count(err_count)
  );

  int total = 0;
  int bad   = 0;
  int ready_mode = 0;   // 0 random, 1 hold low, 2 hold high
  logic [783:0] sent_img;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [783:0] act, input logic [783:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: frame rules applied to accepted bytes, payload kept as a byte queue
  int            m_phase = 0;  // 0 idle, 1 payload, 2 image held, 3 command strobe, 4 trailer
  byte unsigned  m_bytes[$];
  logic [1:0]    m_kind = 2'd0;
  logic [1:0]    m_layer = 2'd0;
  logic [783:0]  m_img = '0;
  int            m_err = 0;
  logic          m_rdy = 1'b0;
  logic          m_acc;
  logic [7:0]    m_d;
  logic [7:0]    m_x;
  int            m_need;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_phase = 0;
      m_img   = '0;
      m_err   = 0;
      m_rdy   = 1'b0;
      m_bytes.delete();
    end else begin
      m_acc = in_valid && m_rdy;
      m_d   = in_data;
      case (m_phase)
        0: if (m_acc) begin
          if (m_d[1:0] == 2'd3 || (m_d[1:0] != 2'd0 && m_d[3:2] == 2'd0)) begin
            m_err = (m_err < 255) ? m_err + 1 : 255;
          end else begin
            m_phase = 1;
            m_kind  = m_d[1:0];
            m_layer = m_d[3:2];
            m_bytes.delete();
            m_img   = '0;
          end
        end
        1: if (m_acc) begin
          m_bytes.push_back(m_d);
          m_img = '0;
          foreach (m_bytes[i]) m_img[i*8 +: 8] = m_bytes[i];
          m_need = (m_kind == 2'd0) ? P_IMG : P_CMD;
          if (m_bytes.size() == m_need) begin
`ifdef FRAME_LOADER_CHECKSUM_EN
            m_phase = 4;
`else
            m_phase = (m_kind == 2'd0) ? 2 : 3;
`endif
          end
        end
        2: if (image_out_ready) m_phase = 0;
        3: m_phase = 0;
        4: if (m_acc) begin
          m_x = 8'd0;
          foreach (m_bytes[i]) m_x = m_x ^ m_bytes[i];
          if (m_d == m_x) m_phase = (m_kind == 2'd0) ? 2 : 3;
          else begin
            m_err   = (m_err < 255) ? m_err + 1 : 255;
            m_phase = 0;
          end
        end
        default: m_phase = 0;
      endcase
      m_rdy = (m_phase == 0) || (m_phase == 1) || (m_phase == 4);
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  initial forever begin
    @(negedge clk);
    chk("in_ready", 784'(in_ready), 784'(m_rdy));
    chk("image_out_valid", 784'(image_out_valid), 784'(m_phase == 2));
    chk("kernel_layer", 784'(kernel_layer), 784'((m_phase == 3 && m_kind == 2'd1) ? m_layer : 2'd0));
    chk("offset_layer", 784'(offset_layer), 784'((m_phase == 3 && m_kind == 2'd2) ? m_layer : 2'd0));
    chk("err_count", 784'(err_count), 784'(m_err));
    chk("image", image, m_img);
  end

  initial begin
    image_out_ready = 1'b0;
    forever begin
      @(negedge clk);
      image_out_ready = (ready_mode == 0) ? 1'($urandom_range(0, 1)) : (ready_mode == 2);
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Called at a negedge; returns at the negedge after the byte was accepted
  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 400 cycles");
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] hdr, input int fill, input int gap, input bit bad_trl);
    int n;
    logic [7:0] b, x;
    logic [1:0] k, l;
    k = hdr[1:0];
    l = hdr[3:2];
    send_byte(hdr, gap);
    if (k == 2'd3 || (k != 2'd0 && l == 2'd0)) return;
    n = (k == 2'd0) ? P_IMG : P_CMD;
    x = 8'd0;
    sent_img = '0;
    for (int i = 0; i < n; i++) begin
      b = (fill < 0) ? 8'($urandom) : 8'(fill);
      x = x ^ b;
      sent_img[i*8 +: 8] = b;
      send_byte(b, (i == n - 1) ? 0 : gap);
    end
`ifdef FRAME_LOADER_CHECKSUM_EN
    send_byte(bad_trl ? (x ^ 8'($urandom_range(1, 255))) : x, 0);
`else
    if (bad_trl) x = ~x;
`endif
  endtask

  function automatic logic [7:0] illegal_hdr();
    int r = $urandom_range(0, 2);
    if (r == 0) return {4'($urandom), 2'($urandom), 2'd3};
    return {4'($urandom), 2'd0, 2'(r)};
  endfunction

  logic [7:0] hdr;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", 784'(in_ready), 784'(0));
    chk("reset_err", 784'(err_count), 784'(0));
    chk("reset_image", image, 784'(0));
    rst = 1'b0;
    @(negedge clk);

    // 0xA5 image, downstream always ready
    ready_mode = 2;
    repeat (2) @(negedge clk);
    send_frame(8'h00, 'hA5, 0, 1'b0);
    chk("a5_valid", 784'(image_out_valid), 784'(1));
    chk("a5_low_byte", 784'(image[7:0]), 784'(8'hA5));
    chk("a5_image", image, {98{8'hA5}});
    @(negedge clk);
    chk("a5_ready_after", 784'(in_ready), 784'(1));
    chk("a5_valid_after", 784'(image_out_valid), 784'(0));

    // Backpressured image
    ready_mode = 1;
    repeat (2) @(negedge clk);
    send_frame(8'hF0, -1, 1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 784'(image_out_valid), 784'(1));
      chk("bp_in_ready", 784'(in_ready), 784'(0));
      chk("bp_image", image, sent_img);
      @(negedge clk);
    end
    ready_mode = 2;
    repeat (3) @(negedge clk);
    chk("bp_released_valid", 784'(image_out_valid), 784'(0));
    chk("bp_released_ready", 784'(in_ready), 784'(1));

    // Kernel command, layer 1
    ready_mode = 0;
    send_frame(8'h05, -1, 0, 1'b0);
    chk("ker_layer", 784'(kernel_layer), 784'(1));
    chk("ker_offset", 784'(offset_layer), 784'(0));
    chk("ker_upper_zero", 784'(image[783:240]), 784'(0));
    @(negedge clk);
    chk("ker_one_cycle", 784'(kernel_layer), 784'(0));

    // Random frames with gaps, random backpressure, occasional illegal headers
    for (int f = 0; f < 40; f++) begin
      hdr = 8'($urandom);
      if ($urandom_range(0, 3) != 0 && hdr[1:0] != 2'd0 && hdr[3:2] == 2'd0) hdr[3:2] = 2'd1;
      send_frame(hdr, -1, $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
    end
    ready_mode = 2;
    repeat (3) @(negedge clk);

    // Reset in the middle of an image payload
    send_byte(8'h00, 0);
    for (int i = 0; i < 50; i++) send_byte(8'($urandom), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_valid", 784'(image_out_valid), 784'(0));
    chk("midrst_ready", 784'(in_ready), 784'(0));
    chk("midrst_image", image, 784'(0));
    chk("midrst_err", 784'(err_count), 784'(0));
    rst = 1'b0;
    @(negedge clk);
    send_frame(8'h00, -1, 0, 1'b0);
    chk("postrst_valid", 784'(image_out_valid), 784'(1));
    chk("postrst_image", image, sent_img);
    repeat (2) @(negedge clk);

    // Error counter saturation
    send_byte(8'h03, 0);
    for (int i = 0; i < 300; i++) send_byte(illegal_hdr(), 0);
    chk("err_saturated", 784'(err_count), 784'(255));
    send_frame(8'h09, -1, 0, 1'b0);
    chk("sat_kernel_layer2", 784'(kernel_layer), 784'(2));
    chk("err_still_sat", 784'(err_count), 784'(255));
    repeat (2) @(negedge clk);

`ifdef FRAME_LOADER_CHECKSUM_EN
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send_frame(8'h0A, -1, 0, 1'b1);
    chk("csum_bad_err", 784'(err_count), 784'(1));
    chk("csum_bad_offset", 784'(offset_layer), 784'(0));
    @(negedge clk);
    chk("csum_bad_offset2", 784'(offset_layer), 784'(0));
    send_frame(8'h0A, -1, 0, 1'b0);
    chk("csum_good_offset", 784'(offset_layer), 784'(2));
    chk("csum_good_err", 784'(err_count), 784'(1));
    @(negedge clk);
    chk("csum_good_once", 784'(offset_layer), 784'(0));
`endif

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
